mux_sel_seq: RTL

Sequencer that sits directly upstream of the 4-to-1 `mux` block. It latches a 4-bit word onto the mux data inputs and steps the mux select through slots 0→3, holding each slot for a programmable number of cycles. It samples the mux output `y` at the end of each slot and reassembles the serialized bits into a 4-bit result word, which closes the loop for self-checking.

---
 rtl/mux_sel_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mux_sel_seq.sv
// rtl/mux_sel_seq.sv - select sequencer and result reassembler for the 4-to-1 mux
//
// Latches a 4-bit word onto the mux data inputs, walks the mux select through
// slots 0..3 holding each for HOLD cycles, samples the mux output at the last
// edge of every slot and rebuilds the word in q.
//
// Optional feature macro: MUX_SEQ_CHECK_EN (compare q against d at completion).
//
// Parameters:
//   HOLD   cycles each select value is held (1..256)
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request a new sequence, sampled while ready=1
//   d_in   in   [3:0] word captured on an accepted start
//   y      in   output of the downstream mux
//   d      out  [3:0] registered word driven to mux.d
//   s      out  [1:0] registered select driven to mux.s
//   ready  out  idle, start will be accepted
//   busy   out  sequence in progress
//   done   out  one-cycle completion pulse, q valid in the same cycle
//   q      out  [3:0] reassembled word, q[i] = y sampled while s=i
//   err    out  q/d mismatch flag (0 when the check is not built)
module mux_sel_seq #(
   parameter int HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] d_in,
   input  logic       y,
   output logic [3:0] d,
   output logic [1:0] s,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [3:0] q,
   output logic       err
);

   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      d_q, d_d;
   logic [1:0]      s_q, s_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      q_q, q_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               d_d     = d_in;
               s_d     = 2'd0;
               cnt_d   = '0;
               q_d     = 4'd0;
               err_d   = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               // last edge of the slot: y has been stable for the whole slot
               cnt_d    = '0;
               q_d[s_q] = y;
               if (s_q == 2'd3) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`ifdef MUX_SEQ_CHECK_EN
                  // compare with the word including the bit captured this edge
                  err_d   = (q_d != d_q);
`endif
               end else begin
                  s_d = s_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= 4'd0;
         s_q     <= 2'd0;
         cnt_q   <= '0;
         q_q     <= 4'd0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign d     = d_q;
   assign s     = s_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign q     = q_q;
`ifdef MUX_SEQ_CHECK_EN
   assign err   = err_q;
`else
   // err_q never leaves 0 here; the output is tied off so no comparator exists
   assign err   = 1'b0;
`endif

endmodule
